// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, registered handshake pulses and any depth from 2 to 1024.
// Optional feature macro: FIFO_FWFT_EN selects first-word-fall-through read
// behaviour; when undefined, data_out is registered with one-cycle read latency.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  // Status flags are decoded straight from the occupancy counter.
  always_comb begin
    full        = (count == DEPTH_CNT);
    empty       = (count == '0);
    almostfull  = (af_thresh != '0) && (count >= af_thresh);
    almostempty = (count != '0) && (count <= ae_thresh);
    // A full FIFO still accepts a read, an empty one still accepts a write,
    // so simultaneous requests at the boundaries resolve naturally.
    wr_accept   = wr_en && !full;
    rd_accept   = rd_en && !empty;
  end

  // Storage array: no reset so it maps onto block RAM; reset discards contents
  // by clearing the pointers and count instead.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and single-cycle handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Pointers wrap explicitly so non-power-of-two depths work.
      if (wr_accept) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_accept) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (wr_accept && !rd_accept) begin
        count <= count + CNT_W'(1);
      end else if (rd_accept && !wr_accept) begin
        count <= count - CNT_W'(1);
      end
      wr_ack    <= wr_accept;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented whenever the FIFO holds data; rd_en pops it.
  always_comb begin
    data_out = '0;
    if (!empty) begin
      data_out = mem[rd_ptr];
    end
  end
`else
  // Registered read: an accepted read loads the head word on the next edge,
  // otherwise the output holds. Reading before the same-edge write gives
  // old data when both hit the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_accept) begin
      data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed self-checking bench for sync_fifo_prog
// (default standard-read mode), with a depth-8 and a depth-6 instance.
module tb_sync_fifo_prog;

  logic clk;
  logic rst_n;

  // depth-8 instance signals
  logic        wr8, rd8;
  logic [15:0] din8, dout8;
  logic [3:0]  af8, ae8, cnt8;
  logic        ack8, ovf8, udf8, full8, empty8, afull8, aempty8;

  // depth-6 instance signals
  logic        wr6, rd6;
  logic [15:0] din6, dout6;
  logic [2:0]  af6, ae6, cnt6;
  logic        ack6, ovf6, udf6, full6, empty6, afull6, aempty6;

  int checks = 0;
  int failures = 0;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr8), .data_in(din8), .rd_en(rd8),
    .af_thresh(af8), .ae_thresh(ae8), .data_out(dout8), .wr_ack(ack8),
    .overflow(ovf8), .underflow(udf8), .full(full8), .empty(empty8),
    .almostfull(afull8), .almostempty(aempty8), .count(cnt8)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr6), .data_in(din6), .rd_en(rd6),
    .af_thresh(af6), .ae_thresh(ae6), .data_out(dout6), .wr_ack(ack6),
    .overflow(ovf6), .underflow(udf6), .full(full6), .empty(empty6),
    .almostfull(afull6), .almostempty(aempty6), .count(cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of depth-8 stimulus, then sample 1 time unit after the edge.
  task automatic step8(input logic w, input logic r, input logic [15:0] d);
    wr8 = w; rd8 = r; din8 = d;
    @(posedge clk); #1;
    wr8 = 1'b0; rd8 = 1'b0;
    $display("txn d8 wr=%0b rd=%0b din=%h -> dout=%h cnt=%0d ack=%0b ovf=%0b udf=%0b",
             w, r, d, dout8, cnt8, ack8, ovf8, udf8);
  endtask

  task automatic step6(input logic w, input logic r, input logic [15:0] d);
    wr6 = w; rd6 = r; din6 = d;
    @(posedge clk); #1;
    wr6 = 1'b0; rd6 = 1'b0;
    $display("txn d6 wr=%0b rd=%0b din=%h -> dout=%h cnt=%0d",
             w, r, d, dout6, cnt6);
  endtask

  initial begin
    rst_n = 1'b0;
    wr8 = 0; rd8 = 0; din8 = '0; af8 = 4'd6; ae8 = 4'd2;
    wr6 = 0; rd6 = 0; din6 = '0; af6 = 3'd5; ae6 = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_count", cnt8, 0);
    check("rst_empty", empty8, 1);
    check("rst_full", full8, 0);
    check("rst_afull", afull8, 0);
    check("rst_aempty", aempty8, 0);
    check("rst_dout", dout8, 0);
    check("rst_ack", ack8, 0);
    rst_n = 1'b1;
    #2;

    // fill 1..8 with flag thresholds af=6, ae=2
    for (int i = 1; i <= 8; i++) begin
      step8(1'b1, 1'b0, 16'(i));
      check("fill_ack", ack8, 1);
      check("fill_count", cnt8, i);
      check("fill_aempty", aempty8, (i <= 2) ? 1 : 0);
      check("fill_afull", afull8, (i >= 6) ? 1 : 0);
    end
    check("full_flag", full8, 1);
    check("full_empty", empty8, 0);

    // write when full
    step8(1'b1, 1'b0, 16'h0009);
    check("ovf_pulse", ovf8, 1);
    check("ovf_noack", ack8, 0);
    check("ovf_count", cnt8, 8);
    step8(1'b0, 1'b0, 16'h0000);
    check("ovf_clear", ovf8, 0);

    // drain in order with one-cycle latency
    for (int i = 1; i <= 8; i++) begin
      step8(1'b0, 1'b1, 16'h0000);
      check("rd_data", dout8, i);
      check("rd_count", cnt8, 8 - i);
    end
    check("drain_empty", empty8, 1);
    step8(1'b0, 1'b1, 16'h0000);
    check("udf_pulse", udf8, 1);
    check("udf_hold", dout8, 16'h0008);
    step8(1'b0, 1'b0, 16'h0000);
    check("udf_clear", udf8, 0);

    // refill and hit full with simultaneous read/write
    for (int i = 1; i <= 8; i++) step8(1'b1, 1'b0, 16'(16'h0010 + i));
    check("refill_full", full8, 1);
    step8(1'b1, 1'b1, 16'h00FF);
    check("both_full_ovf", ovf8, 1);
    check("both_full_count", cnt8, 7);
    check("both_full_dout", dout8, 16'h0011);
    check("both_full_noack", ack8, 0);

    // drain remaining, then simultaneous read/write while empty
    for (int i = 2; i <= 8; i++) step8(1'b0, 1'b1, 16'h0000);
    check("drain2_dout", dout8, 16'h0018);
    check("drain2_empty", empty8, 1);
    step8(1'b1, 1'b1, 16'h0A5A);
    check("both_empty_ack", ack8, 1);
    check("both_empty_udf", udf8, 1);
    check("both_empty_count", cnt8, 1);
    step8(1'b0, 1'b1, 16'h0000);
    check("both_empty_data", dout8, 16'h0A5A);
    check("both_empty_cnt0", cnt8, 0);

    // asynchronous reset mid-transfer at count=5
    for (int i = 1; i <= 5; i++) step8(1'b1, 1'b0, 16'(16'h0020 + i));
    step8(1'b0, 1'b1, 16'h0000);
    step8(1'b1, 1'b0, 16'h0026);
    check("pre_rst_count", cnt8, 5);
    check("pre_rst_dout", dout8, 16'h0021);
    rst_n = 1'b0;
    #1;
    check("arst_count", cnt8, 0);
    check("arst_empty", empty8, 1);
    check("arst_dout", dout8, 0);
    #1;
    rst_n = 1'b1;
    step8(1'b0, 1'b1, 16'h0000);
    check("post_rst_udf", udf8, 1);
    check("post_rst_dout", dout8, 0);
    step8(1'b1, 1'b0, 16'h0BEE);
    check("post_rst_ack", ack8, 1);
    step8(1'b0, 1'b1, 16'h0000);
    check("post_rst_data", dout8, 16'h0BEE);

    // depth-6 wrap: keep 2 entries in flight over 20 paired write/read cycles
    step6(1'b1, 1'b0, 16'h0100);
    step6(1'b1, 1'b0, 16'h0101);
    check("d6_prefill", cnt6, 2);
    for (int k = 0; k < 20; k++) begin
      step6(1'b1, 1'b1, 16'(16'h0102 + k));
      check("d6_data", dout6, 16'(16'h0100 + k));
      check("d6_count", cnt6, 2);
    end
    for (int k = 0; k < 4; k++) step6(1'b1, 1'b0, 16'(16'h0200 + k));
    check("d6_full", full6, 1);
    check("d6_count_full", cnt6, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
